// File: rtl/btn_event_classifier.sv
// btn_event_classifier: turns a clean, synchronous button level into press/release/click/long pulses.
// Optional auto-repeat while long-held is built only when BTN_AUTOREPEAT_EN is defined.
module btn_event_classifier #(
    parameter int unsigned LONG_PRESS_CYCLES = 499,
    parameter int unsigned DBL_GAP_CYCLES    = 199,
    parameter int unsigned REPEAT_CYCLES     = 99,
    parameter int unsigned CNT_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             single_pulse,
    output logic             double_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned MAX_LD = (LONG_PRESS_CYCLES > DBL_GAP_CYCLES) ? LONG_PRESS_CYCLES : DBL_GAP_CYCLES;
    localparam int unsigned MAX_T  = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
    localparam int unsigned TW     = (MAX_T > 0) ? $clog2(MAX_T + 1) : 1;
    localparam logic [TW-1:0] LONG_T = TW'(LONG_PRESS_CYCLES);
    localparam logic [TW-1:0] GAP_T  = TW'(DBL_GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_PRESSED
    } state_e;

    state_e            state_q, state_d;
    logic              btn_prev_q;
    logic [TW-1:0]     timer_q, timer_d;
    logic              rise, fall;
    logic              press_d, release_d, single_d, double_d, long_d, held_d;
    logic              press_q, release_q, single_q, double_q, long_q, held_q;
    logic [CNT_W-1:0]  count_q;

    assign rise = btn_in & ~btn_prev_q;
    assign fall = ~btn_in & btn_prev_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:           if (rise) state_d = PRESSED;
            PRESSED: begin
                if (fall)                   state_d = WAIT_GAP;
                else if (timer_q == LONG_T) state_d = LONG_HELD;
            end
            LONG_HELD:      if (fall) state_d = IDLE;
            WAIT_GAP: begin
                if (rise)                  state_d = SECOND_PRESSED;
                else if (timer_q == GAP_T) state_d = IDLE;
            end
            SECOND_PRESSED: if (fall) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Edge checks take priority over timer matches, so simultaneous events resolve to click/double.
    always_comb begin
        press_d   = rise & ((state_q == IDLE) | (state_q == WAIT_GAP));
        double_d  = rise & (state_q == WAIT_GAP);
        release_d = fall & ((state_q == PRESSED) | (state_q == LONG_HELD) | (state_q == SECOND_PRESSED));
        single_d  = ~rise & (state_q == WAIT_GAP) & (timer_q == GAP_T);
        long_d    = ~fall & (state_q == PRESSED) & (timer_q == LONG_T);
        held_d    = (state_d == PRESSED) | (state_d == LONG_HELD) | (state_d == SECOND_PRESSED);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [TW-1:0] REP_T = TW'(REPEAT_CYCLES);
    logic repeat_d, repeat_q;

    assign repeat_d = ~fall & (state_q == LONG_HELD) & (timer_q == REP_T);

    always_ff @(posedge clk) begin
        if (rst) repeat_q <= 1'b0;
        else     repeat_q <= repeat_d;
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else begin
            unique case (state_q)
                PRESSED, WAIT_GAP: timer_d = timer_q + 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                LONG_HELD:         timer_d = (timer_q == REP_T) ? '0 : timer_q + 1'b1;
`endif
                default:           timer_d = timer_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
            timer_q    <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            single_q   <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            btn_prev_q <= btn_in;
            timer_q    <= timer_d;
            press_q    <= press_d;
            release_q  <= release_d;
            single_q   <= single_d;
            double_q   <= double_d;
            long_q     <= long_d;
            held_q     <= held_d;
            count_q    <= count_q + CNT_W'(press_d);
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_pulse  = single_q;
    assign double_pulse  = double_q;
    assign long_pulse    = long_q;
    assign held          = held_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_btn_event_classifier.sv
// Directed bench for btn_event_classifier: expected pulses are queued per cycle and checked every cycle.
module tb_btn_event_classifier;

    localparam int unsigned LP = 9;
    localparam int unsigned DG = 4;
    localparam int unsigned RC = 2;
    localparam int unsigned CW = 2;

    localparam logic [5:0] M_P  = 6'b000001;
    localparam logic [5:0] M_R  = 6'b000010;
    localparam logic [5:0] M_S  = 6'b000100;
    localparam logic [5:0] M_D  = 6'b001000;
    localparam logic [5:0] M_L  = 6'b010000;
    localparam logic [5:0] M_RP = 6'b100000;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_in;
    logic          press_pulse, release_pulse, single_pulse, double_pulse;
    logic          long_pulse, repeat_pulse, held;
    logic [CW-1:0] press_count;

    always #5 clk = ~clk;

    btn_event_classifier #(
        .LONG_PRESS_CYCLES(LP),
        .DBL_GAP_CYCLES   (DG),
        .REPEAT_CYCLES    (RC),
        .CNT_W            (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .single_pulse (single_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    typedef struct {
        int         at;
        logic [5:0] mask;
    } ev_t;

    ev_t           sb[$];
    int            cyc      = 0;
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_cnt  = '0;

    task automatic expect_at(input int at, input logic [5:0] m);
        ev_t e;
        e.at   = at;
        e.mask = m;
        sb.push_back(e);
        if (m[0]) exp_cnt = exp_cnt + 1'b1;
    endtask

    // One clock; then every pulse output is compared with what the queue holds for this cycle.
    task automatic step();
        logic [5:0] exp_m;
        logic [5:0] obs;
        @(posedge clk);
        #1;
        cyc++;
        exp_m = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                exp_m = exp_m | sb[i].mask;
                sb.delete(i);
            end
        end
        obs = {repeat_pulse, long_pulse, double_pulse, single_pulse, release_pulse, press_pulse};
        n_assert++;
        assert (obs === exp_m) else begin
            n_fail++;
            $error("FAIL pulses@%0d observed=%b expected=%b (rp,l,d,s,r,p)", cyc, obs, exp_m);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst    = 1'b1;
        btn_in = 1'b0;
        step();
        chk("rst_held", {7'b0, held}, 8'd0);
        chk("rst_cnt", 8'(press_count), 8'd0);
        step();
        rst = 1'b0;

        // short click
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        expect_at(t + 4, M_R);
        expect_at(t + 9, M_S);
        repeat (3) step();
        chk("click_held", {7'b0, held}, 8'd1);
        chk("click_cnt", 8'(press_count), 8'(exp_cnt));
        btn_in = 1'b0;
        repeat (8) step();
        chk("click_held_off", {7'b0, held}, 8'd0);

        // long press, 20 cycles
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        expect_at(t + 11, M_L);
        expect_at(t + 21, M_R);
`ifdef BTN_AUTOREPEAT_EN
        expect_at(t + 14, M_RP);
        expect_at(t + 17, M_RP);
        expect_at(t + 20, M_RP);
`endif
        repeat (20) begin
            step();
            chk("long_held", {7'b0, held}, 8'd1);
        end
        btn_in = 1'b0;
        repeat (8) step();
        chk("long_held_off", {7'b0, held}, 8'd0);
        chk("long_cnt", 8'(press_count), 8'(exp_cnt));

        // double click: 2 high, 2 low, 2 high
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        expect_at(t + 3, M_R);
        expect_at(t + 5, M_P | M_D);
        expect_at(t + 7, M_R);
        repeat (2) step();
        btn_in = 1'b0;
        repeat (2) step();
        btn_in = 1'b1;
        repeat (2) step();
        chk("dbl_held", {7'b0, held}, 8'd1);
        btn_in = 1'b0;
        repeat (8) step();
        chk("dbl_cnt", 8'(press_count), 8'(exp_cnt));

        // release on the same edge as the long-press timer match
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        expect_at(t + 11, M_R);
        expect_at(t + 16, M_S);
        repeat (10) step();
        btn_in = 1'b0;
        repeat (8) step();

        // second rise on the same edge as the gap timer match
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        expect_at(t + 3, M_R);
        expect_at(t + 8, M_P | M_D);
        expect_at(t + 10, M_R);
        repeat (2) step();
        btn_in = 1'b0;
        repeat (5) step();
        btn_in = 1'b1;
        repeat (2) step();
        btn_in = 1'b0;
        repeat (8) step();

        // second rise one cycle too late: single, then a fresh press
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        expect_at(t + 3, M_R);
        expect_at(t + 8, M_S);
        expect_at(t + 9, M_P);
        expect_at(t + 11, M_R);
        expect_at(t + 16, M_S);
        repeat (2) step();
        btn_in = 1'b0;
        repeat (6) step();
        btn_in = 1'b1;
        repeat (2) step();
        btn_in = 1'b0;
        repeat (8) step();

        // reset while PRESSED with timer at 5
        t = cyc;
        btn_in = 1'b1;
        expect_at(t + 1, M_P);
        repeat (6) step();
        rst = 1'b1;
        step();
        exp_cnt = '0;
        chk("midrst_held", {7'b0, held}, 8'd0);
        chk("midrst_cnt", 8'(press_count), 8'd0);
        rst    = 1'b0;
        btn_in = 1'b0;
        repeat (15) step();

        // five clicks wrap the 2-bit counter 3 -> 0 -> 1
        repeat (5) begin
            t = cyc;
            btn_in = 1'b1;
            expect_at(t + 1, M_P);
            expect_at(t + 2, M_R);
            expect_at(t + 7, M_S);
            step();
            btn_in = 1'b0;
            repeat (7) step();
        end
        chk("wrap_cnt", 8'(press_count), 8'(exp_cnt));
        chk("wrap_cnt_abs", 8'(press_count), 8'd1);

        // button already high when reset is released counts as a press
        btn_in = 1'b1;
        rst    = 1'b1;
        step();
        exp_cnt = '0;
        chk("hi_rst_held", {7'b0, held}, 8'd0);
        rst = 1'b0;
        t = cyc;
        expect_at(t + 1, M_P);
        expect_at(t + 4, M_R);
        expect_at(t + 9, M_S);
        repeat (3) step();
        chk("hi_rst_held_on", {7'b0, held}, 8'd1);
        btn_in = 1'b0;
        repeat (8) step();
        chk("hi_rst_cnt", 8'(press_count), 8'(exp_cnt));

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
